reg_file_sequencer: RTL and testbench
=====================================

// Module: reg_file_sequencer
// PURPOSE
//  Initiator/controller side of the reg_file interface. It accepts one instruction per
//  valid/ready handshake and sequences reg_file reads (RA1/RA2) and the write-back (WA,
//  write_enable, ALUResult). An internal 8-bit ALU computes the write-back value from RD1/RD2.
//  Sits between the instruction source and reg_file; one instruction is in flight at a time.
// PARAMETERS
//  DATA_WIDTH  8  width of RD1/RD2/ALUResult
//  ADDR_WIDTH  4  register address width; instr width = 4 + 3*ADDR_WIDTH (16 at defaults)
// PORTS
//  CLK            in   1     clock, all state updates on rising edge
//  RESET          in   1     synchronous, active-high reset
//  instr          in   16    [15:12] opcode, [11:8] rd (WA), [7:4] rs1 (RA1), [3:0] rs2 (RA2)
//  instr_valid    in   1     instr present
//  instr_ready    out  1     sequencer can accept (high only in IDLE)
//  RD1            in   8     reg_file read data for RA1 (combinational in reg_file)
//  RD2            in   8     reg_file read data for RA2
//  RA1            out  4     read address 1
//  RA2            out  4     read address 2
//  WA             out  4     write address
//  ALUResult      out  8     write-back data
//  write_enable   out  1     reg_file write strobe
//  done           out  1     1-cycle pulse, instruction retired
//  illegal_op     out  1     1-cycle pulse with done when opcode is reserved
// BEHAVIOUR
//  Reset: state=IDLE; RA1=RA2=WA=0, ALUResult=0, write_enable=0, done=0, illegal_op=0,
//   instr_ready=1 in the cycle after reset deasserts.
//  FSM: IDLE -> READ -> EXEC -> WRITE -> IDLE, one cycle per state except IDLE.
//   IDLE : instr_ready=1. On instr_valid&&instr_ready, latch instr -> READ. instr is ignored otherwise.
//   READ : RA1=rs1, RA2=rs2 (registered from the latched instr). At the edge leaving READ,
//          RD1/RD2 are captured into operand regs A/B.
//   EXEC : ALUResult <= f(op, A, B); WA <= rd.
//   WRITE: write_enable=1 (except NOP/illegal); ALUResult and WA are stable; reg_file writes
//          at the edge leaving WRITE; done=1 for this cycle -> IDLE.
//  Latency: accept edge to write edge = 3 cycles. Throughput: 1 instr per 4 cycles.
//  Opcodes (mod 2^DATA_WIDTH wrap, no saturation):
//   0 NOP (no write)  1 ADD A+B  2 SUB A-B  3 AND  4 OR  5 XOR  6 LDI imm=instr[7:0]
//   7 MOV A  8 NOT ~A  9-15 reserved: no write, illegal_op=1 with done.
//  write_enable is decoded only from the state/opcode flops (glitch-free); it is 0 outside WRITE.
//  rd == rs1/rs2 is legal: operands are captured before write-back, so old values are used.
//  RESET in any state: abort at that edge, no write issued, outputs take reset values.
//  instr_valid held high across the retirement cycle: the next instr is accepted in the
//   first IDLE cycle after WRITE (no same-cycle accept in WRITE).
// CONFIGURATION
//  STATUS_FLAGS_EN defined: extra outputs zero_flag, carry_flag (1 bit each), updated at
//   the EXEC edge for ops 1-5,7,8 and held otherwise. zero=(result==0);
//   carry=ADD bit DATA_WIDTH out / SUB borrow (A<B) / 0 for logic ops. Reset to 0.
//  Undefined: ports absent, no flag logic.
// TESTING
//  1 RESET high 2 cycles -> write_enable=0, ALUResult=0, instr_ready=1 after release.
//  2 LDI rd=1 imm=8'h15 -> WRITE cycle: WA=1, ALUResult=8'h15, write_enable=1, done=1.
//  3 ADD rd=2 rs1=1 rs2=1, RD1=RD2=8'h15 -> ALUResult=8'h2A in WRITE; 3 cycles accept->write.
//  4 SUB rd=15 rs1=3 rs2=4, RD1=8'h01 RD2=8'h02 -> ALUResult=8'hFF; carry_flag=1 if STATUS_FLAGS_EN.
//  5 opcode 4'hC -> done=1, illegal_op=1, write_enable never asserted.
//  6 RESET asserted during EXEC of ADD -> no write_enable pulse, IDLE next cycle.

Source files
------------

// File: rtl/reg_file_sequencer.sv
// Instruction sequencer driving a reg_file through the READ/EXEC/WRITE phases, with an internal ALU.
// Optional STATUS_FLAGS_EN adds zero_flag/carry_flag outputs updated by arithmetic/logic ops.
module reg_file_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [4+3*ADDR_WIDTH-1:0] instr,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [DATA_WIDTH-1:0]     RD1,
  input  logic [DATA_WIDTH-1:0]     RD2,
  output logic [ADDR_WIDTH-1:0]     RA1,
  output logic [ADDR_WIDTH-1:0]     RA2,
  output logic [ADDR_WIDTH-1:0]     WA,
  output logic [DATA_WIDTH-1:0]     ALUResult,
  output logic                      write_enable,
  output logic                      done,
  output logic                      illegal_op
`ifdef STATUS_FLAGS_EN
  ,
  output logic                      zero_flag,
  output logic                      carry_flag
`endif
);

  localparam int IW = 4 + 3*ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              op_p0;
  logic [ADDR_WIDTH-1:0]   rd_p0;
  logic [DATA_WIDTH-1:0]   imm_p0;
  logic [DATA_WIDTH-1:0]   op_a_p1, op_b_p1;
  logic                    accept;

  function automatic logic [DATA_WIDTH-1:0] alu_f(input logic [3:0] op,
                                                  input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b,
                                                  input logic [DATA_WIDTH-1:0] imm);
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return imm;
      4'd7:    return a;
      4'd8:    return ~a;
      default: return '0;
    endcase
  endfunction

`ifdef STATUS_FLAGS_EN
  function automatic logic alu_carry(input logic [3:0] op,
                                     input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      4'd1:    return sum[DATA_WIDTH];
      4'd2:    return a < b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic flag_op(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd5) || op == 4'd7 || op == 4'd8;
  endfunction
`endif

  assign accept = (state_q == S_IDLE) && instr_valid;

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode only from the state and opcode flops so they cannot glitch.
  always_comb begin
    instr_ready  = (state_q == S_IDLE);
    done         = (state_q == S_WRITE);
    write_enable = (state_q == S_WRITE) && (op_p0 >= 4'd1) && (op_p0 <= 4'd8);
    illegal_op   = (state_q == S_WRITE) && (op_p0 >= 4'd9);
  end

  // Accept / READ: latch instruction fields, then capture operands leaving READ
  always_ff @(posedge CLK) begin
    if (accept) begin
      rd_p0  <= instr[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
      imm_p0 <= instr[DATA_WIDTH-1:0];
    end
    if (state_q == S_READ) begin
      op_a_p1 <= RD1;
      op_b_p1 <= RD2;
    end
  end

  // EXEC: result and write address registered for the WRITE cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_p0      <= '0;
      RA1        <= '0;
      RA2        <= '0;
      WA         <= '0;
      ALUResult  <= '0;
`ifdef STATUS_FLAGS_EN
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_p0 <= instr[IW-1 -: 4];
        RA1   <= instr[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
        RA2   <= instr[ADDR_WIDTH-1:0];
      end
      if (state_q == S_EXEC) begin
        ALUResult <= alu_f(op_p0, op_a_p1, op_b_p1, imm_p0);
        WA        <= rd_p0;
`ifdef STATUS_FLAGS_EN
        if (flag_op(op_p0)) begin
          zero_flag  <= (alu_f(op_p0, op_a_p1, op_b_p1, imm_p0) == '0);
          carry_flag <= alu_carry(op_p0, op_a_p1, op_b_p1);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Directed bench for reg_file_sequencer with a behavioural reg_file attached to RA/WA ports.
// Flag checks are compiled in when STATUS_FLAGS_EN is defined.
module tb_reg_file_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  RD1, RD2;
  logic [3:0]  RA1, RA2, WA;
  logic [7:0]  ALUResult;
  logic        write_enable, done, illegal_op;
`ifdef STATUS_FLAGS_EN
  logic        zero_flag, carry_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rf [16];

  reg_file_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .RD1(RD1), .RD2(RD2), .RA1(RA1), .RA2(RA2),
    .WA(WA), .ALUResult(ALUResult), .write_enable(write_enable),
    .done(done), .illegal_op(illegal_op)
`ifdef STATUS_FLAGS_EN
    , .zero_flag(zero_flag), .carry_flag(carry_flag)
`endif
  );

  always #5 CLK = ~CLK;

  assign RD1 = rf[RA1];
  assign RD2 = rf[RA2];

  always @(posedge CLK) if (write_enable) rf[WA] <= ALUResult;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_instr(input logic [15:0] ins, input int exp_res, input int exp_we,
                           input int exp_ill, input int exp_z, input int exp_c);
    check_eq("ready_idle", 32'(instr_ready), 1);
    instr = ins;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check_eq("ra1_read", 32'(RA1), 32'(ins[7:4]));
    check_eq("ra2_read", 32'(RA2), 32'(ins[3:0]));
    check_eq("we_read", 32'(write_enable), 0);
    check_eq("ready_busy", 32'(instr_ready), 0);
    tick();
    check_eq("we_exec", 32'(write_enable), 0);
    check_eq("done_exec", 32'(done), 0);
    tick();
    check_eq("done_write", 32'(done), 1);
    check_eq("we_write", 32'(write_enable), 32'(exp_we));
    check_eq("illegal_write", 32'(illegal_op), 32'(exp_ill));
    check_eq("wa_write", 32'(WA), 32'(ins[11:8]));
    if (exp_we != 0) check_eq("result_write", 32'(ALUResult), 32'(exp_res));
`ifdef STATUS_FLAGS_EN
    check_eq("zero_flag", 32'(zero_flag), 32'(exp_z));
    check_eq("carry_flag", 32'(carry_flag), 32'(exp_c));
`endif
    tick();
    check_eq("done_after", 32'(done), 0);
    check_eq("we_after", 32'(write_enable), 0);
  endtask

  initial begin
    RESET = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    tick();
    tick();
    check_eq("rst_we", 32'(write_enable), 0);
    check_eq("rst_result", 32'(ALUResult), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_illegal", 32'(illegal_op), 0);
    check_eq("rst_ra1", 32'(RA1), 0);
    check_eq("rst_wa", 32'(WA), 0);
    RESET = 1'b0;
    tick();
    check_eq("rst_ready", 32'(instr_ready), 1);

    // ins, result, we, illegal, zero, carry
    run_instr(16'h6115, 'h15, 1, 0, 0, 0);   // LDI r1 = 15
    run_instr(16'h1211, 'h2A, 1, 0, 0, 0);   // ADD r2 = r1 + r1
    run_instr(16'h6301, 'h01, 1, 0, 0, 0);   // LDI r3 = 01
    run_instr(16'h6402, 'h02, 1, 0, 0, 0);   // LDI r4 = 02
    run_instr(16'h2F34, 'hFF, 1, 0, 0, 1);   // SUB r15 = 01 - 02 (borrow)
    run_instr(16'h3712, 'h00, 1, 0, 1, 0);   // AND 15 & 2A
    run_instr(16'h4812, 'h3F, 1, 0, 0, 0);   // OR
    run_instr(16'h5912, 'h3F, 1, 0, 0, 0);   // XOR
    run_instr(16'h7A20, 'h2A, 1, 0, 0, 0);   // MOV r10 = r2
    run_instr(16'h8B10, 'hEA, 1, 0, 0, 0);   // NOT r11 = ~15
    run_instr(16'h6CFF, 'hFF, 1, 0, 0, 0);   // LDI r12 = FF, flags held
    run_instr(16'h1DC3, 'h00, 1, 0, 1, 1);   // ADD FF + 01 wraps
    run_instr(16'h0000, 0, 0, 0, 1, 1);      // NOP, flags held
    run_instr(16'hC123, 0, 0, 1, 1, 1);      // reserved opcode
    run_instr(16'h1111, 'h2A, 1, 0, 0, 0);   // rd == rs: old r1 used
    check_eq("rf_r1", 32'(rf[1]), 'h2A);
    check_eq("rf_r15", 32'(rf[15]), 'hFF);

    // instr_valid held through retirement: next accept only after WRITE
    instr = 16'h7E10;
    instr_valid = 1'b1;
    tick();
    tick();
    tick();
    check_eq("hold_done", 32'(done), 1);
    check_eq("hold_result", 32'(ALUResult), 'h2A);
    instr = 16'h8E10;
    tick();
    check_eq("hold_idle_ready", 32'(instr_ready), 1);
    check_eq("hold_idle_done", 32'(done), 0);
    tick();
    instr_valid = 1'b0;
    check_eq("hold_accept", 32'(instr_ready), 0);
    check_eq("hold_ra1", 32'(RA1), 1);
    tick();
    tick();
    check_eq("hold2_done", 32'(done), 1);
    check_eq("hold2_result", 32'(ALUResult), 'hD5);
    check_eq("hold2_wa", 32'(WA), 'hE);
    tick();

    // Reset during EXEC of ADD r3 = r1 + r1
    instr = 16'h1311;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    check_eq("abort_we", 32'(write_enable), 0);
    check_eq("abort_done", 32'(done), 0);
    check_eq("abort_ready", 32'(instr_ready), 1);
    check_eq("abort_result", 32'(ALUResult), 0);
    check_eq("abort_wa", 32'(WA), 0);
`ifdef STATUS_FLAGS_EN
    check_eq("abort_zero", 32'(zero_flag), 0);
    check_eq("abort_carry", 32'(carry_flag), 0);
`endif
    RESET = 1'b0;
    tick();
    check_eq("post_abort_we", 32'(write_enable), 0);
    check_eq("post_abort_ready", 32'(instr_ready), 1);
    check_eq("rf_r3_kept", 32'(rf[3]), 'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
